// File: rtl/parking_lot_controller.sv
// parking_lot_controller: 4-spot occupancy keeper and entry-gate sequencer.
// Entry assigns the lowest free spot and opens the gate for GATE_CYCLES cycles.
module parking_lot_controller #(
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic [3:0] exit_spot,
  output logic [3:0] state,
  output logic [3:0] next_spot,
  output logic [2:0] free_count,
  output logic       full,
  output logic       busy,
  output logic       entry_gate,
  output logic       assign_valid,
  output logic [3:0] assigned_spot,
  output logic       err_full,
  output logic       err_exit
);

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } fsm_e;

  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES - 1);

  fsm_e       fsm_q;
  logic [3:0] cnt_q;
  logic [3:0] state_q, state_d;
  logic       assign_valid_q;
  logic [3:0] assigned_spot_q;
  logic       err_full_q;
  logic       err_exit_q;

  logic       admit;
  logic       exit_ok;
  logic [3:0] set_mask;
  logic [3:0] exit_mask;
  logic [3:0] clr_mask;

  // Spot number (1..4) to one-hot state bit; anything else maps to no bit.
  function automatic logic [3:0] spot_mask(input logic [3:0] spot);
    logic [3:0] m;
    m = 4'b0000;
    unique case (spot)
      4'd1:    m = 4'b0001;
      4'd2:    m = 4'b0010;
      4'd3:    m = 4'b0100;
      4'd4:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Lowest-numbered free spot, spot 1 has priority; 0 when the lot is full.
  always_comb begin
    next_spot = 4'd0;
    priority case (1'b1)
      !state_q[0]: next_spot = 4'd1;
      !state_q[1]: next_spot = 4'd2;
      !state_q[2]: next_spot = 4'd3;
      !state_q[3]: next_spot = 4'd4;
      default:     next_spot = 4'd0;
    endcase
  end

  assign free_count = 3'(!state_q[0]) + 3'(!state_q[1])
                    + 3'(!state_q[2]) + 3'(!state_q[3]);
  assign full       = &state_q;

  // Entry and exit both decide from the pre-edge occupancy, so the bit an
  // admission sets is always free and the bit an exit clears is always taken.
  always_comb begin
    admit     = (fsm_q == IDLE) && enter_req && !full;
    set_mask  = admit ? spot_mask(next_spot) : 4'b0000;
    exit_mask = spot_mask(exit_spot);
    exit_ok   = exit_req && ((exit_mask & state_q) != 4'b0000);
    clr_mask  = exit_ok ? exit_mask : 4'b0000;
    state_d   = (state_q & ~clr_mask) | set_mask;
  end

  // Occupancy register and the exit-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= 4'b0000;
      err_exit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_exit_q <= exit_req && !exit_ok;
    end
  end

  // Entry FSM with gate counter and registered admission/refusal outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q           <= IDLE;
      cnt_q           <= 4'd0;
      assign_valid_q  <= 1'b0;
      assigned_spot_q <= 4'd0;
      err_full_q      <= 1'b0;
    end else begin
      assign_valid_q <= 1'b0;
      err_full_q     <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (enter_req) begin
            if (full) begin
              err_full_q <= 1'b1;
            end else begin
              assigned_spot_q <= next_spot;
              assign_valid_q  <= 1'b1;
              cnt_q           <= GATE_LOAD;
              fsm_q           <= GATE;
            end
          end
        end
        GATE: begin
          if (cnt_q == 4'd0) begin
            fsm_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state         = state_q;
  assign busy          = (fsm_q == GATE);
  assign entry_gate    = (fsm_q == GATE);
  assign assign_valid  = assign_valid_q;
  assign assigned_spot = assigned_spot_q;
  assign err_full      = err_full_q;
  assign err_exit      = err_exit_q;

endmodule

// File: tb/tb_parking_lot_controller.sv
// tb_parking_lot_controller: directed vector table for the lot controller,
// plus a hand-written gate-width sequence.
module tb_parking_lot_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       enter_req;
  logic       exit_req;
  logic [3:0] exit_spot;
  logic [3:0] state;
  logic [3:0] next_spot;
  logic [2:0] free_count;
  logic       full;
  logic       busy;
  logic       entry_gate;
  logic       assign_valid;
  logic [3:0] assigned_spot;
  logic       err_full;
  logic       err_exit;

  int n_vec = 0;
  int n_bad = 0;

  parking_lot_controller #(.GATE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enter_req    (enter_req),
    .exit_req     (exit_req),
    .exit_spot    (exit_spot),
    .state        (state),
    .next_spot    (next_spot),
    .free_count   (free_count),
    .full         (full),
    .busy         (busy),
    .entry_gate   (entry_gate),
    .assign_valid (assign_valid),
    .assigned_spot(assigned_spot),
    .err_full     (err_full),
    .err_exit     (err_exit)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       en;
    bit       ex;
    bit [3:0] spot;
    bit [3:0] st;
    bit       av;
    bit [3:0] asp;
    bit       ef;
    bit       ee;
    bit       bz;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input bit r, input bit en, input bit ex,
                              input bit [3:0] spot, input bit [3:0] st,
                              input bit av, input bit [3:0] asp,
                              input bit ef, input bit ee, input bit bz);
    vec_t v;
    v.rst = r; v.en = en; v.ex = ex; v.spot = spot;
    v.st = st; v.av = av; v.asp = asp;
    v.ef = ef; v.ee = ee; v.bz = bz;
    tv.push_back(v);
  endfunction

  function automatic int exp_next(input bit [3:0] st);
    for (int i = 0; i < 4; i++) if (!st[i]) return i + 1;
    return 0;
  endfunction

  function automatic int exp_free(input bit [3:0] st);
    int c = 0;
    for (int i = 0; i < 4; i++) if (!st[i]) c++;
    return c;
  endfunction

  task automatic chk(input int idx, input string name,
                     input int act, input int exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  initial begin
    int hi;
    int wait_cnt;
    rst = 1'b1; enter_req = 1'b0; exit_req = 1'b0; exit_spot = 4'd0;

    //  rst en ex spot  state  av asp ef ee bz
    add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0); // 0 reset
    add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 4'b0001, 1, 1, 0, 0, 1); // car 1
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 4'b0011, 1, 2, 0, 0, 1); // car 2
    add(0, 0, 0, 0, 4'b0011, 0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0011, 0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0011, 0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0011, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 4'b0011, 0, 2, 0, 0, 0);
    add(0, 1, 0, 0, 4'b0111, 1, 3, 0, 0, 1); // car 3
    add(0, 0, 0, 0, 4'b0111, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0111, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0111, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0111, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 4'b0111, 0, 3, 0, 0, 0);
    add(0, 1, 0, 0, 4'b1111, 1, 4, 0, 0, 1); // car 4 -> full
    add(0, 0, 0, 0, 4'b1111, 0, 4, 0, 0, 1);
    add(0, 1, 0, 0, 4'b1111, 0, 4, 0, 0, 1); // enter in GATE ignored
    add(0, 0, 0, 0, 4'b1111, 0, 4, 0, 0, 1);
    add(0, 0, 0, 0, 4'b1111, 0, 4, 0, 0, 0);
    add(0, 1, 0, 0, 4'b1111, 0, 4, 1, 0, 0); // full -> err_full
    add(0, 0, 0, 0, 4'b1111, 0, 4, 0, 0, 0);
    add(0, 0, 1, 2, 4'b1101, 0, 4, 0, 0, 0); // exit spot 2
    add(0, 1, 0, 0, 4'b1111, 1, 2, 0, 0, 1); // refill spot 2
    add(0, 0, 0, 0, 4'b1111, 0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 4'b1111, 0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 4'b1111, 0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 4'b1111, 0, 2, 0, 0, 0);
    add(0, 1, 1, 4, 4'b0111, 0, 2, 1, 0, 0); // full enter + exit 4
    add(0, 0, 0, 0, 4'b0111, 0, 2, 0, 0, 0);
    add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0); // reset
    add(0, 1, 0, 0, 4'b0001, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0);
    add(0, 0, 1, 3, 4'b0001, 0, 1, 0, 1, 0); // exit free spot
    add(0, 0, 1, 0, 4'b0001, 0, 1, 0, 1, 0); // exit spot 0
    add(0, 0, 1, 7, 4'b0001, 0, 1, 0, 1, 0); // exit spot 7
    add(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0010, 1, 2, 0, 0, 1); // enter + exit 1
    add(0, 0, 0, 0, 4'b0010, 0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0010, 0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0010, 0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 4'b0010, 0, 2, 0, 0, 0);
    add(0, 1, 0, 0, 4'b0011, 1, 1, 0, 0, 1); // refill spot 1
    add(0, 0, 0, 0, 4'b0011, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0); // reset mid-GATE
    add(0, 1, 0, 0, 4'b0001, 1, 1, 0, 0, 1); // held enter
    add(0, 1, 0, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 4'b0001, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 4'b0011, 1, 2, 0, 0, 1); // next admission
    add(0, 0, 0, 0, 4'b0011, 0, 2, 0, 0, 1);

    foreach (tv[i]) begin
      @(negedge clk);
      rst       = tv[i].rst;
      enter_req = tv[i].en;
      exit_req  = tv[i].ex;
      exit_spot = tv[i].spot;
      @(posedge clk);
      #1;
      n_vec++;
      chk(i, "state",         state,         tv[i].st);
      chk(i, "next_spot",     next_spot,     exp_next(tv[i].st));
      chk(i, "free_count",    free_count,    exp_free(tv[i].st));
      chk(i, "full",          full,          (tv[i].st == 4'b1111));
      chk(i, "busy",          busy,          tv[i].bz);
      chk(i, "entry_gate",    entry_gate,    tv[i].bz);
      chk(i, "assign_valid",  assign_valid,  tv[i].av);
      chk(i, "assigned_spot", assigned_spot, tv[i].asp);
      chk(i, "err_full",      err_full,      tv[i].ef);
      chk(i, "err_exit",      err_exit,      tv[i].ee);
    end

    // Gate width: after an admission the gate stays high exactly 4 cycles.
    @(negedge clk);
    rst = 1'b1; enter_req = 1'b0; exit_req = 1'b0; exit_spot = 4'd0;
    @(negedge clk);
    rst = 1'b0; enter_req = 1'b1;
    @(negedge clk);
    enter_req = 1'b0;
    hi = 0;
    wait_cnt = 0;
    while (entry_gate && wait_cnt < 20) begin
      hi++;
      wait_cnt++;
      @(negedge clk);
    end
    n_vec++;
    chk(-1, "gate_width", hi, 4);
    n_vec++;
    chk(-1, "gate_state", state, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
